// File: rtl/ex_stage_if.sv
// ID/EX-to-EX/MEM bundle for the MIPS execute stage.
// master = upstream pipeline side, slave = ex_stage.
interface ex_stage_if;
    localparam int unsigned RegBus     = 32;
    localparam int unsigned RegAddrBus = 5;
    localparam int unsigned AluOpBus   = 8;
    localparam int unsigned AluSelBus  = 3;

    logic [AluOpBus-1:0]   aluop_i;
    logic [AluSelBus-1:0]  alusel_i;
    logic [RegBus-1:0]     reg1_i;
    logic [RegBus-1:0]     reg2_i;
    logic [RegAddrBus-1:0] wd_i;
    logic                  wreg_i;
    logic [RegBus-1:0]     link_address_i;

    logic [RegAddrBus-1:0] wd_o;
    logic                  wreg_o;
    logic [RegBus-1:0]     wdata_o;
    logic                  whilo_o;
    logic [RegBus-1:0]     hi_o;
    logic [RegBus-1:0]     lo_o;
    logic                  stallreq_o;

    modport master (
        output aluop_i, alusel_i, reg1_i, reg2_i, wd_i, wreg_i, link_address_i,
        input  wd_o, wreg_o, wdata_o, whilo_o, hi_o, lo_o, stallreq_o
    );

    modport slave (
        input  aluop_i, alusel_i, reg1_i, reg2_i, wd_i, wreg_i, link_address_i,
        output wd_o, wreg_o, wdata_o, whilo_o, hi_o, lo_o, stallreq_o
    );
endinterface

// File: rtl/ex_stage.sv
// MIPS execute stage: single-cycle ALU plus a 32-step restoring divider
// that stalls the pipeline until the HI/LO result is ready.
module ex_stage (
    input  logic        clk,
    input  logic        rst,
    ex_stage_if.slave   bus
);
    localparam int unsigned RegBus = 32;

    localparam logic [7:0] OP_AND  = 8'b0010_0100;
    localparam logic [7:0] OP_OR   = 8'b0010_0101;
    localparam logic [7:0] OP_XOR  = 8'b0010_0110;
    localparam logic [7:0] OP_NOR  = 8'b0010_0111;
    localparam logic [7:0] OP_SLL  = 8'b0111_1100;
    localparam logic [7:0] OP_SRL  = 8'b0000_0010;
    localparam logic [7:0] OP_SRA  = 8'b0000_0011;
    localparam logic [7:0] OP_SLT  = 8'b0010_1010;
    localparam logic [7:0] OP_SLTU = 8'b0010_1011;
    localparam logic [7:0] OP_ADD  = 8'b0010_0000;
    localparam logic [7:0] OP_ADDU = 8'b0010_0001;
    localparam logic [7:0] OP_SUB  = 8'b0010_0010;
    localparam logic [7:0] OP_SUBU = 8'b0010_0011;
    localparam logic [7:0] OP_DIV  = 8'b0001_1010;
    localparam logic [7:0] OP_DIVU = 8'b0001_1011;

    localparam logic [2:0] RES_LOGIC       = 3'b001;
    localparam logic [2:0] RES_SHIFT       = 3'b010;
    localparam logic [2:0] RES_ARITHMETIC  = 3'b100;
    localparam logic [2:0] RES_JUMP_BRANCH = 3'b110;

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_BUSY = 2'd1,
        S_DONE = 2'd2
    } div_state_e;

    div_state_e state_q, state_d;

    logic [RegBus-1:0] a, b;
    logic [RegBus-1:0] sum, diff, alu_res;
    logic              add_ov, sub_ov, suppress_wr;
    logic              is_div, is_sdiv;

    logic [RegBus-1:0] quo_q, rem_q, dvs_q;
    logic              neg_q_q, neg_r_q;
    logic [4:0]        cnt_q;
    logic [RegBus:0]   trial;
    logic [RegBus-1:0] abs_a, abs_b;

    assign a       = bus.reg1_i;
    assign b       = bus.reg2_i;
    assign is_div  = (bus.aluop_i == OP_DIV) || (bus.aluop_i == OP_DIVU);
    assign is_sdiv = (bus.aluop_i == OP_DIV);

    // Single-cycle ALU result and signed-overflow detection
    always_comb begin
        alu_res     = '0;
        sum         = a + b;
        diff        = a - b;
        add_ov      = (a[31] == b[31]) && (sum[31] != a[31]);
        sub_ov      = (a[31] != b[31]) && (diff[31] != a[31]);
        suppress_wr = ((bus.aluop_i == OP_ADD) && add_ov) ||
                      ((bus.aluop_i == OP_SUB) && sub_ov);
        case (bus.alusel_i)
            RES_LOGIC: begin
                case (bus.aluop_i)
                    OP_AND:  alu_res = a & b;
                    OP_OR:   alu_res = a | b;
                    OP_XOR:  alu_res = a ^ b;
                    OP_NOR:  alu_res = ~(a | b);
                    default: alu_res = '0;
                endcase
            end
            RES_SHIFT: begin
                case (bus.aluop_i)
                    OP_SLL:  alu_res = b << a[4:0];
                    OP_SRL:  alu_res = b >> a[4:0];
                    OP_SRA:  alu_res = 32'($signed(b) >>> a[4:0]);
                    default: alu_res = '0;
                endcase
            end
            RES_ARITHMETIC: begin
                case (bus.aluop_i)
                    OP_ADD, OP_ADDU: alu_res = sum;
                    OP_SUB, OP_SUBU: alu_res = diff;
                    OP_SLT:  alu_res = 32'($signed(a) < $signed(b));
                    OP_SLTU: alu_res = 32'(a < b);
                    default: alu_res = '0;
                endcase
            end
            RES_JUMP_BRANCH: alu_res = bus.link_address_i;
            default:         alu_res = '0;
        endcase
    end

    // Operand magnitudes and one restoring shift-subtract trial
    always_comb begin
        abs_a = (is_sdiv && a[31]) ? (~a + 32'd1) : a;
        abs_b = (is_sdiv && b[31]) ? (~b + 32'd1) : b;
        trial = {rem_q, quo_q[31]} - {1'b0, dvs_q};
    end

    // Divider state register
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) state_q <= S_IDLE;
        else      state_q <= state_d;
    end

    // Divider next-state
    always_comb begin
        state_d = state_q;
        case (state_q)
            S_IDLE: if (is_div) state_d = (b == '0) ? S_DONE : S_BUSY;
            S_BUSY: if (cnt_q == 5'd31) state_d = S_DONE;
            S_DONE: state_d = S_IDLE;
            default: state_d = S_IDLE;
        endcase
    end

    // Divider datapath; quo_q holds the dividend and shifts quotient bits in
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            quo_q   <= '0;
            rem_q   <= '0;
            dvs_q   <= '0;
            neg_q_q <= 1'b0;
            neg_r_q <= 1'b0;
            cnt_q   <= '0;
        end else begin
            case (state_q)
                S_IDLE: begin
                    if (is_div) begin
                        cnt_q   <= '0;
                        rem_q   <= '0;
                        neg_q_q <= is_sdiv && (a[31] != b[31]);
                        neg_r_q <= is_sdiv && a[31];
                        quo_q   <= (b == '0) ? '0 : abs_a;
                        dvs_q   <= abs_b;
                    end
                end
                S_BUSY: begin
                    cnt_q <= cnt_q + 5'd1;
                    if (!trial[RegBus]) begin
                        rem_q <= trial[RegBus-1:0];
                        quo_q <= {quo_q[30:0], 1'b1};
                    end else begin
                        rem_q <= {rem_q[30:0], quo_q[31]};
                        quo_q <= {quo_q[30:0], 1'b0};
                    end
                end
                default: ;
            endcase
        end
    end

    // Outputs; everything forced low while reset is asserted
    always_comb begin
        bus.wd_o       = '0;
        bus.wreg_o     = 1'b0;
        bus.wdata_o    = '0;
        bus.whilo_o    = 1'b0;
        bus.hi_o       = '0;
        bus.lo_o       = '0;
        bus.stallreq_o = 1'b0;
        if (rst) begin
            bus.wd_o       = bus.wd_i;
            bus.wdata_o    = alu_res;
            bus.wreg_o     = bus.wreg_i && !suppress_wr;
            bus.stallreq_o = is_div && (state_q != S_DONE);
            if (is_div && (state_q == S_DONE)) begin
                bus.whilo_o = 1'b1;
                bus.wreg_o  = 1'b0;
                bus.lo_o    = neg_q_q ? (~quo_q + 32'd1) : quo_q;
                bus.hi_o    = neg_r_q ? (~rem_q + 32'd1) : rem_q;
            end
        end
    end
endmodule

// File: tb/tb_ex_stage.sv
// Directed bench for ex_stage: ALU vectors, divider latency/results,
// divide-by-zero, reset abort and back-to-back divides.
module tb_ex_stage;
    localparam logic [7:0] OP_NOP  = 8'h00;
    localparam logic [7:0] OP_AND  = 8'b0010_0100;
    localparam logic [7:0] OP_OR   = 8'b0010_0101;
    localparam logic [7:0] OP_NOR  = 8'b0010_0111;
    localparam logic [7:0] OP_SLL  = 8'b0111_1100;
    localparam logic [7:0] OP_SRL  = 8'b0000_0010;
    localparam logic [7:0] OP_SRA  = 8'b0000_0011;
    localparam logic [7:0] OP_SLT  = 8'b0010_1010;
    localparam logic [7:0] OP_SLTU = 8'b0010_1011;
    localparam logic [7:0] OP_ADD  = 8'b0010_0000;
    localparam logic [7:0] OP_ADDU = 8'b0010_0001;
    localparam logic [7:0] OP_SUB  = 8'b0010_0010;
    localparam logic [7:0] OP_SUBU = 8'b0010_0011;
    localparam logic [7:0] OP_DIV  = 8'b0001_1010;
    localparam logic [7:0] OP_DIVU = 8'b0001_1011;

    localparam logic [2:0] RES_NOP   = 3'b000;
    localparam logic [2:0] RES_LOGIC = 3'b001;
    localparam logic [2:0] RES_SHIFT = 3'b010;
    localparam logic [2:0] RES_ARITH = 3'b100;
    localparam logic [2:0] RES_JB    = 3'b110;
    localparam logic [2:0] RES_MUL   = 3'b101;

    logic clk = 1'b0;
    logic rst;
    int   n_total = 0;
    int   n_pass  = 0;
    int   n_fail  = 0;

    ex_stage_if bus();
    ex_stage dut (.clk(clk), .rst(rst), .bus(bus));

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_total++;
        assert (obs === exp) n_pass++;
        else begin
            n_fail++;
            $error("FAIL %s: observed %08h expected %08h", tag, obs, exp);
        end
    endtask

    task automatic drive(input logic [7:0] op, input logic [2:0] sel,
                         input logic [31:0] r1, input logic [31:0] r2,
                         input logic [4:0] wd, input logic wr, input logic [31:0] link);
        bus.aluop_i        = op;
        bus.alusel_i       = sel;
        bus.reg1_i         = r1;
        bus.reg2_i         = r2;
        bus.wd_i           = wd;
        bus.wreg_i         = wr;
        bus.link_address_i = link;
        #1;
    endtask

    // Issue a divide from IDLE, count stall cycles, then check the DONE cycle
    task automatic run_div(input string tag, input logic [7:0] op,
                           input logic [31:0] r1, input logic [31:0] r2,
                           input logic [31:0] exp_lo, input logic [31:0] exp_hi,
                           input int exp_stalls);
        int   stalls = 0;
        logic saw_whilo = 1'b0;
        drive(op, RES_NOP, r1, r2, 5'd3, 1'b1, 32'h0);
        while (bus.stallreq_o === 1'b1 && stalls < 100) begin
            if (bus.whilo_o !== 1'b0) saw_whilo = 1'b1;
            stalls++;
            @(posedge clk); #2;
        end
        check({tag, "_stalls"}, 32'(stalls), 32'(exp_stalls));
        check({tag, "_early_whilo"}, 32'(saw_whilo), 32'd0);
        check({tag, "_whilo"}, 32'(bus.whilo_o), 32'd1);
        check({tag, "_lo"}, bus.lo_o, exp_lo);
        check({tag, "_hi"}, bus.hi_o, exp_hi);
        check({tag, "_wreg"}, 32'(bus.wreg_o), 32'd0);
        @(posedge clk); #1;
    endtask

    initial begin
        logic saw_whilo;
        rst = 1'b0;
        drive(OP_ADDU, RES_ARITH, 32'h7FFF_FFFF, 32'h1, 5'd5, 1'b1, 32'h0);
        @(posedge clk); #2;
        check("rst_wdata", bus.wdata_o, 32'h0);
        check("rst_wreg", 32'(bus.wreg_o), 32'd0);
        check("rst_wd", 32'(bus.wd_o), 32'd0);
        drive(OP_DIVU, RES_NOP, 32'd9, 32'd2, 5'd5, 1'b1, 32'h0);
        check("rst_stall", 32'(bus.stallreq_o), 32'd0);
        check("rst_whilo_hi_lo", {31'd0, bus.whilo_o} | bus.hi_o | bus.lo_o, 32'h0);
        drive(OP_NOP, RES_NOP, 32'h0, 32'h0, 5'd0, 1'b0, 32'h0);
        @(negedge clk);
        rst = 1'b1;
        @(posedge clk); #1;

        drive(OP_ADD, RES_ARITH, 32'h7FFF_FFFF, 32'h1, 5'd5, 1'b1, 32'h0);
        check("add_ov_wreg", 32'(bus.wreg_o), 32'd0);
        check("add_stall", 32'(bus.stallreq_o), 32'd0);
        drive(OP_ADDU, RES_ARITH, 32'h7FFF_FFFF, 32'h1, 5'd5, 1'b1, 32'h0);
        check("addu_wdata", bus.wdata_o, 32'h8000_0000);
        check("addu_wreg", 32'(bus.wreg_o), 32'd1);
        check("addu_wd", 32'(bus.wd_o), 32'd5);
        drive(OP_ADD, RES_ARITH, 32'hFFFF_FFFE, 32'h5, 5'd7, 1'b1, 32'h0);
        check("add_wdata", bus.wdata_o, 32'h0000_0003);
        check("add_wreg", 32'(bus.wreg_o), 32'd1);
        drive(OP_SUB, RES_ARITH, 32'h0, 32'h8000_0000, 5'd7, 1'b1, 32'h0);
        check("sub_ov_wreg", 32'(bus.wreg_o), 32'd0);
        drive(OP_SUBU, RES_ARITH, 32'h8000_0000, 32'h1, 5'd7, 1'b1, 32'h0);
        check("subu_wdata", bus.wdata_o, 32'h7FFF_FFFF);
        check("subu_wreg", 32'(bus.wreg_o), 32'd1);
        drive(OP_SRA, RES_SHIFT, 32'd4, 32'h8000_0010, 5'd1, 1'b1, 32'h0);
        check("sra", bus.wdata_o, 32'hF800_0001);
        drive(OP_SRL, RES_SHIFT, 32'd4, 32'h8000_0010, 5'd1, 1'b1, 32'h0);
        check("srl", bus.wdata_o, 32'h0800_0001);
        drive(OP_SLL, RES_SHIFT, 32'd36, 32'h0000_00F1, 5'd1, 1'b1, 32'h0);
        check("sll", bus.wdata_o, 32'h0000_0F10);
        drive(OP_SLTU, RES_ARITH, 32'hFFFF_FFFF, 32'h1, 5'd2, 1'b1, 32'h0);
        check("sltu", bus.wdata_o, 32'h0);
        drive(OP_SLT, RES_ARITH, 32'hFFFF_FFFF, 32'h1, 5'd2, 1'b1, 32'h0);
        check("slt", bus.wdata_o, 32'h1);
        drive(OP_AND, RES_LOGIC, 32'hF0F0_1234, 32'hFF00_FF00, 5'd2, 1'b1, 32'h0);
        check("and", bus.wdata_o, 32'hF000_1200);
        drive(OP_OR, RES_LOGIC, 32'hF0F0_1234, 32'h0F00_0001, 5'd2, 1'b1, 32'h0);
        check("or", bus.wdata_o, 32'hFFF0_1235);
        drive(OP_NOR, RES_LOGIC, 32'hF0F0_0000, 32'h0000_FF00, 5'd2, 1'b1, 32'h0);
        check("nor", bus.wdata_o, 32'h0F0F_00FF);
        drive(OP_NOP, RES_JB, 32'h1, 32'h2, 5'd31, 1'b1, 32'h0040_0108);
        check("link", bus.wdata_o, 32'h0040_0108);
        drive(OP_ADDU, RES_MUL, 32'h1, 32'h2, 5'd4, 1'b1, 32'h0);
        check("other_sel", bus.wdata_o, 32'h0);
        check("other_whilo", 32'(bus.whilo_o), 32'd0);

        run_div("div_m7_2", OP_DIV, 32'hFFFF_FFF9, 32'd2, 32'hFFFF_FFFD, 32'hFFFF_FFFF, 33);
        run_div("divu_by0", OP_DIVU, 32'hFFFF_FFFF, 32'd0, 32'h0, 32'h0, 1);

        // Abort a DIVU 100/7 with reset ten cycles into BUSY
        saw_whilo = 1'b0;
        drive(OP_DIVU, RES_NOP, 32'd100, 32'd7, 5'd3, 1'b1, 32'h0);
        for (int i = 0; i < 10; i++) begin
            @(posedge clk); #2;
            if (bus.whilo_o !== 1'b0) saw_whilo = 1'b1;
        end
        rst = 1'b0;
        #1;
        check("abort_whilo", 32'(saw_whilo | bus.whilo_o), 32'd0);
        check("abort_stall", 32'(bus.stallreq_o), 32'd0);
        @(negedge clk);
        rst = 1'b1;
        run_div("divu_restart", OP_DIVU, 32'd100, 32'd7, 32'd14, 32'd2, 33);

        run_div("b2b_divu", OP_DIVU, 32'd100, 32'd7, 32'd14, 32'd2, 33);
        run_div("b2b_div", OP_DIV, 32'hFFFF_FFF7, 32'd4, 32'hFFFF_FFFE, 32'hFFFF_FFFF, 33);

        drive(OP_NOP, RES_NOP, 32'h0, 32'h0, 5'd0, 1'b0, 32'h0);
        check("idle_whilo", 32'(bus.whilo_o), 32'd0);
        check("idle_stall", 32'(bus.stallreq_o), 32'd0);

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end
endmodule

// File: doc/ex_stage.md
# ex_stage

Execute stage of the five-stage MIPS pipeline, directly downstream of the ID/EX pipeline register and feeding the EX/MEM register. Computes logic, shift, add/subtract/compare and link results in a single cycle. Executes DIV/DIVU on an internal 32-step iterative divider, holding the pipeline through `stallreq_o` until HI/LO results are ready.

## Interface
- No parameters; widths come from `RegBus` (32), `RegAddrBus` (5), `AluOpBus` (8) and `AluSelBus` (3).
- clk  in  1  pipeline clock.
- rst  in  1  asynchronous, active-low reset.
- aluop_i  in  AluOpBus  operation from ID/EX.
- alusel_i  in  AluSelBus  result class from ID/EX.
- reg1_i, reg2_i  in  32  source operands.
- wd_i  in  5  destination register.
- wreg_i  in  1  write enable.
- link_address_i  in  32  return address for link instructions.
- wd_o  out  5  destination register to EX/MEM.
- wreg_o  out  1  write enable to EX/MEM.
- wdata_o  out  32  GPR write data.
- whilo_o  out  1  HI/LO write enable.
- hi_o, lo_o  out  32  HI/LO write data.
- stallreq_o  out  1  EX stall request to ctrl.

## Operation
- Result selection is by alusel_i:
  - EXE_RES_LOGIC: AND/OR/XOR/NOR of reg1_i and reg2_i.
  - EXE_RES_SHIFT: SLL/SRL/SRA of reg2_i by reg1_i[4:0].
  - EXE_RES_ARITHMETIC: ADD/ADDU/SUB/SUBU/SLT/SLTU. SLT is a signed compare; SLTU is unsigned. Result is 1 or 0.
  - EXE_RES_JUMP_BRANCH: wdata_o = link_address_i.
  - Any other class or unknown aluop: wdata_o = 0.
- Overflow on ADD/SUB (signed 32-bit wrap):
  - wreg_o = 0, no exception.
  - ADDU/SUBU never suppress the write.
  - Otherwise wreg_o = wreg_i and wd_o = wd_i.
- Arithmetic is modulo 2^32. Compare results are zero-extended.
- Divider FSM has three states: IDLE, BUSY, DONE.
  - IDLE with aluop DIV/DIVU and divisor ≠ 0:
    - Latch |dividend| and |divisor| (raw values for DIVU).
    - Record quotient and remainder signs.
    - cnt = 0, go to BUSY.
  - IDLE with DIV/DIVU and divisor = 0: go straight to DONE with quotient = 0, remainder = 0.
  - BUSY: one restoring shift-subtract step per cycle, cnt increments. At cnt = 31 the step completes and the FSM goes to DONE.
  - DONE: results are valid. Unconditionally return to IDLE next cycle.
- Signed correction in DIV:
  - Quotient is negated if the operand signs differ.
  - Remainder takes the dividend's sign.
  - lo_o = quotient, hi_o = remainder.
- whilo_o = 1 only in DONE while aluop_i is DIV/DIVU. In that cycle:
  - hi_o/lo_o carry the result.
  - wreg_o = 0 (DIV writes no GPR).
- Otherwise whilo_o = 0, hi_o = 0, lo_o = 0.
- stallreq_o = 1 when aluop_i is DIV/DIVU and state ≠ DONE (combinational).
- ctrl responds to stallreq_o by freezing PC, IF/ID and ID/EX, so the EX inputs stay stable for the whole division.
- A DIV arriving while ID/EX injects a bubble is impossible: the bubble is NOP.

## Timing
- Non-divide ops: zero latency. Outputs are combinational from the ID/EX registers, and stallreq_o = 0.
- DIV/DIVU, nonzero divisor: 34 cycles in EX.
  - Cycle 0 in IDLE, cycles 1–32 in BUSY, cycle 33 in DONE.
  - stallreq_o is high in cycles 0–32 (33 cycles) and low in cycle 33.
  - The next instruction enters EX at the edge ending cycle 33.
- Divide by zero: 2 cycles (IDLE, DONE); stallreq_o high for 1 cycle.
- Back-to-back DIVs: the second DIV sees IDLE on its first EX cycle and restarts cleanly. There is no dead cycle beyond DONE→IDLE.
- Reset (rst low, asynchronous):
  - state = IDLE, cnt = 0, and the divider datapath registers are cleared.
  - While rst is low, all outputs are forced to 0: wd_o, wreg_o, wdata_o, whilo_o, hi_o, lo_o, stallreq_o.
- Reset mid-division: the operation is abandoned, with no whilo_o pulse. After release the FSM starts from IDLE.
- Reset deassertion is taken synchronously into the FSM. The first post-reset edge is a normal IDLE cycle.

## Test plan
- ADD with reg1 = 0x7FFFFFFF, reg2 = 1, wreg_i = 1 -> wreg_o = 0. Same operands with ADDU -> wdata_o = 0x80000000, wreg_o = 1.
- SRA with reg2 = 0x80000010, reg1 = 4 -> wdata_o = 0xF8000001. SLTU 0xFFFFFFFF vs 1 -> 0; SLT on the same operands -> 1.
- DIV with reg1 = -7, reg2 = 2 -> stallreq_o high for exactly 33 cycles, then one DONE cycle with whilo_o = 1, lo_o = 0xFFFFFFFD, hi_o = 0xFFFFFFFF, wreg_o = 0.
- DIVU with reg1 = 0xFFFFFFFF, reg2 = 0 -> stallreq_o high 1 cycle, then whilo_o = 1 with hi_o = 0, lo_o = 0.
- rst pulled low at BUSY cycle 10 of a DIVU 100/7, then released with the same inputs held -> no whilo_o during the aborted run. The division restarts, giving lo_o = 14, hi_o = 2 after 33 stall cycles.
- DIVU 100/7 immediately followed by DIV -9/4 -> the first finishes with lo_o = 14, hi_o = 2. The second starts on the next cycle and finishes with lo_o = 0xFFFFFFFE, hi_o = 0xFFFFFFFF.
